// File: rtl/psq_guard_array.sv
// Multi-channel plasma-protection interlock: per-channel limit compare with
// persistence filtering, latched kill with minimum hold, and an operator clear handshake.
module psq_guard_array #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned W        = 16,
    parameter int unsigned PERSIST  = 3,
    parameter int unsigned HOLD_MIN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [NCH*W-1:0] meas,
    input  logic [NCH*W-1:0] limit_hi,
    input  logic [NCH*W-1:0] limit_lo,
    input  logic [NCH-1:0]   ch_enable,
    input  logic             clear_req,
    output logic             kill_pulse,
    output logic [1:0]       status,
    output logic [NCH-1:0]   trip_mask,
    output logic [3:0]       first_trip,
    output logic             clear_ack
);

    localparam int unsigned CW    = 8;
    localparam int unsigned HW    = 16;
    localparam logic [CW-1:0] P_MAX  = CW'(PERSIST);
    localparam logic [CW-1:0] P_M1   = CW'(PERSIST - 1);
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD_MIN);
    localparam bit            P_ONE  = (PERSIST == 1);

    typedef enum logic [1:0] {
        S_OK      = 2'b00,
        S_WARN    = 2'b01,
        S_TRIP    = 2'b11,
        S_RECOVER = 2'b10
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt     [NCH];
    logic [CW-1:0]   cnt_nxt [NCH];
    logic [HW-1:0]   hold;
    logic [NCH-1:0]  viol;
    logic [NCH-1:0]  hit;
    logic            any_hit;
    logic            cnt_zero;
    logic            cnt_nxt_zero;
    logic [3:0]      hit_idx;

    assign status  = state;
    assign any_hit = |hit;

    // Limit compare, persistence counter next-state, and hit detection per channel
    always_comb begin
        viol         = '0;
        hit          = '0;
        cnt_zero     = 1'b1;
        cnt_nxt_zero = 1'b1;
        hit_idx      = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            cnt_nxt[i] = cnt[i];
            viol[i] = ch_enable[i] &&
                      ((meas[i*W +: W] > limit_hi[i*W +: W]) ||
                       (meas[i*W +: W] < limit_lo[i*W +: W]));
            hit[i]  = sample_valid && viol[i] && (P_ONE || (cnt[i] == P_M1));
            if (!ch_enable[i]) begin
                cnt_nxt[i] = '0;
            end else if (sample_valid) begin
                if (viol[i]) begin
                    cnt_nxt[i] = (cnt[i] >= P_MAX) ? P_MAX : cnt[i] + CW'(1);
                end else begin
                    cnt_nxt[i] = '0;
                end
            end
            if (cnt[i] != '0) begin
                cnt_zero = 1'b0;
            end
            if (cnt_nxt[i] != '0) begin
                cnt_nxt_zero = 1'b0;
            end
        end
        // Scan downward so the lowest set index wins
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = 4'(i);
            end
        end
    end

    // Interlock state machine with latched kill and sticky trip record
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OK;
            kill_pulse <= 1'b0;
            trip_mask  <= '0;
            first_trip <= '0;
            clear_ack  <= 1'b0;
            hold       <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            clear_ack <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (any_hit) begin
                // A hit always wins, including over a simultaneous clear
                state      <= S_TRIP;
                kill_pulse <= 1'b1;
                trip_mask  <= trip_mask | hit;
                hold       <= HOLD_C;
                if (trip_mask == '0) begin
                    first_trip <= hit_idx;
                end
            end else begin
                case (state)
                    S_OK: begin
                        if (!cnt_nxt_zero) begin
                            state <= S_WARN;
                        end
                    end
                    S_WARN: begin
                        if (cnt_nxt_zero) begin
                            state <= S_OK;
                        end
                    end
                    S_TRIP: begin
                        if (hold < HW'(2)) begin
                            state <= S_RECOVER;
                            hold  <= '0;
                        end else begin
                            hold <= hold - HW'(1);
                        end
                    end
                    S_RECOVER: begin
                        // Release only once every channel is quiet, now and after this sample
                        if (clear_req && cnt_zero && cnt_nxt_zero) begin
                            state      <= S_OK;
                            kill_pulse <= 1'b0;
                            trip_mask  <= '0;
                            first_trip <= '0;
                            clear_ack  <= 1'b1;
                        end
                    end
                    default: state <= S_OK;
                endcase
            end
        end
    end

endmodule

// File: doc/psq_guard_array.md
# psq_guard_array

Parametrised multi-channel safety interlock for the PSQ plasma-protection path. It compares NCH unsigned measurement channels against per-channel high/low limits and filters each channel through a consecutive-violation persistence counter. It raises a latched kill_pulse with a guaranteed minimum hold time. Release requires an explicit operator clear handshake. The block sits between the sampled diagnostics (vertical position, q95, etc.) and the disruption-mitigation trigger.

## Interface
- NCH, 4: number of monitored channels (1..16).
- W, 16: measurement/limit width, unsigned.
- PERSIST, 3: consecutive violating samples required to trip (1..255).
- HOLD_MIN, 16: minimum cycles kill stays asserted before clear is possible (1..65535).

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  meas bus holds a new sample this cycle.
- meas  in  NCH*W  channel i at [i*W +: W].
- limit_hi  in  NCH*W  per-channel upper limit (violation if meas > hi).
- limit_lo  in  NCH*W  per-channel lower limit (violation if meas < lo).
- ch_enable  in  NCH  per-channel enable; disabled channels never violate.
- clear_req  in  1  operator clear request, single-cycle pulse.
- kill_pulse  out  1  disruption trigger, latched.
- status  out  2  00 OK, 01 WARN, 11 TRIP, 10 RECOVER.
- trip_mask  out  NCH  channels that reached PERSIST since last clear (sticky OR).
- first_trip  out  4  lowest-index channel of the first trip event since last clear.
- clear_ack  out  1  one-cycle pulse when a clear is accepted.

## Operation
- viol[i] = ch_enable[i] & (meas_i > hi_i | meas_i < lo_i); unsigned W-bit compares, equality is not a violation.
- Per-channel counter cnt[i], 8 bit:
  - On sample_valid & viol[i]: increments, saturating at PERSIST.
  - On sample_valid & !viol[i]: clears to 0.
  - Without sample_valid: holds.
  - Forced to 0 any cycle ch_enable[i]=0.
- hit[i] = sample_valid & viol[i] & (cnt[i] == PERSIST-1). For PERSIST=1, hit[i] = sample_valid & viol[i].
- Any hit: kill_pulse<=1, trip_mask |= hit, hold counter loaded with HOLD_MIN, state<=TRIP.
  - If trip_mask was 0 before this hit, first_trip <= lowest set index of hit.
- FSM:
  - OK: no cnt nonzero. Goes to WARN if any cnt becomes nonzero without a hit. Goes to TRIP on hit.
  - WARN: returns to OK when all cnt are 0. Goes to TRIP on hit.
  - TRIP: hold counter decrements each cycle. Goes to RECOVER when it reaches 0, i.e. exactly HOLD_MIN cycles in TRIP. A new hit reloads the counter and ORs into trip_mask; first_trip is unchanged.
  - RECOVER: kill_pulse stays 1.
    - A hit returns the FSM to TRIP (reload, OR mask).
    - A clear_req with all cnt == 0 and no hit in the same cycle is accepted: next cycle state OK, kill_pulse 0, trip_mask 0, first_trip 0, clear_ack 1 for one cycle.
- clear_req is ignored, with no memory or ack, in OK, WARN, or TRIP, or in RECOVER when any cnt is nonzero.
- Simultaneous hit and clear_req: the hit wins.

## Timing
- Reset (rst=1 at an edge): kill_pulse 0, status 00, trip_mask 0, first_trip 0, clear_ack 0, all cnt 0, hold counter 0. Reset mid-trip drops kill_pulse on the next edge.
- Trip latency: kill_pulse and status=11 are visible the cycle after the edge that samples the PERSIST-th consecutive violating sample.
- Kill duration: at least HOLD_MIN+1 cycles. Clear is accepted no earlier than the first RECOVER cycle.
- Clear latency: kill_pulse falls and clear_ack rises in the cycle after the accepting edge.
- All outputs are registered; there is no combinational input-to-output path.
- Non-consecutive sample_valid is allowed: persistence counts samples, not cycles.

## Test plan
- NCH=4, PERSIST=3, ch0 hi=0x0033 lo=0: three consecutive valid samples with meas0=0x0034 -> kill_pulse=1 one cycle after the third sample, status 11, trip_mask=0001, first_trip=0.
- ch1 lo=0x0200: samples 0x01FF, 0x01FF, 0x0200, 0x01FF -> no trip, status 01 then 00 then 01, kill_pulse stays 0. Boundary 0x0200 does not violate.
- Channels 1 and 3 hit on the same sample -> trip_mask=1010, first_trip=1. A later ch2 hit in TRIP -> trip_mask=1110, first_trip still 1, hold reloaded.
- HOLD_MIN=16: clear_req at trip+5 ignored (no ack). At the first RECOVER cycle with clean samples, clear_req -> clear_ack pulse, kill_pulse 0, status 00, trip_mask 0.
- In RECOVER, clear_req in the same cycle as a new hit -> no ack, status 11, kill stays 1. ch_enable[0]=0 with meas0 out of limits -> never trips.
- rst asserted for one cycle during TRIP -> all outputs 0 next cycle. Subsequent clean samples keep status 00.
